// File: rtl/sig_delay_line.sv
// Clocked replacement for a transport delay: delays a WIDTH-bit rail bundle by a
// runtime-selectable whole number of cycles, with fill tracking and range checking.
module sig_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               MAX_DELAY = 16,
  parameter int               DEF_DELAY = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              SEL_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             dly_sel_en,
  input  logic [SEL_W-1:0] dly_sel,
  output logic [WIDTH-1:0] out,
  output logic             primed,
  output logic             dly_err
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DELAY);
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEF_DELAY);

  logic [WIDTH-1:0] hist_reg [MAX_DELAY];
  logic [SEL_W-1:0] fill_count_reg;
  logic             dly_err_reg;
  logic             sel_over;
  logic [SEL_W-1:0] eff_delay;
  logic [WIDTH-1:0] tap_val;

  assign sel_over = dly_sel > MAX_SEL;

  // Out-of-range requests clamp to the deepest tap rather than wrapping.
  always_comb begin
    eff_delay = DEF_SEL;
    if (dly_sel_en) begin
      eff_delay = sel_over ? MAX_SEL : dly_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_DELAY; k++) begin
        hist_reg[k] <= RESET_VAL;
      end
    end else begin
      hist_reg[0] <= in;
      for (int k = 1; k < MAX_DELAY; k++) begin
        hist_reg[k] <= hist_reg[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count_reg <= '0;
      dly_err_reg    <= 1'b0;
    end else begin
      if (fill_count_reg != MAX_SEL) begin
        fill_count_reg <= fill_count_reg + 1'b1;
      end
      dly_err_reg <= dly_sel_en & sel_over;
    end
  end

  // Tap select is combinational so a delay change lands in the same cycle; N=0 bypasses history.
  always_comb begin
    tap_val = in;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (eff_delay == SEL_W'(k + 1)) begin
        tap_val = hist_reg[k];
      end
    end
  end

  assign out     = tap_val;
  assign primed  = fill_count_reg >= eff_delay;
  assign dly_err = dly_err_reg;

endmodule

// File: tb/tb_sig_delay_line.sv
// Bench for sig_delay_line: directed scenarios plus random traffic against a
// queue-based model of "the sample captured N edges ago since the last reset".
module tb_sig_delay_line;

  localparam int W    = 2;
  localparam int MAXD = 16;
  localparam int DEFD = 1;
  localparam int SW   = $clog2(MAXD + 1);
  localparam logic [W-1:0] RV = '0;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_v  = '0;
  logic          en    = 1'b0;
  logic [SW-1:0] sel   = '0;
  logic [W-1:0]  out_v;
  logic          primed;
  logic          dly_err;

  int total = 0;
  int bad   = 0;

  // Model state: samples since reset (newest first), edges since reset, registered error.
  logic [W-1:0] hq[$];
  int           fill_m = 0;
  logic         err_m  = 1'b0;

  always #10 clk = ~clk;

  sig_delay_line #(
    .WIDTH    (W),
    .MAX_DELAY(MAXD),
    .DEF_DELAY(DEFD),
    .RESET_VAL(RV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_v),
    .dly_sel_en(en),
    .dly_sel   (sel),
    .out       (out_v),
    .primed    (primed),
    .dly_err   (dly_err)
  );

  function automatic int eff_n();
    if (!en) return DEFD;
    if (int'(sel) > MAXD) return MAXD;
    return int'(sel);
  endfunction

  task automatic check(input string tag);
    int           n;
    logic [W-1:0] exp_out;
    logic         exp_pr;
    n = eff_n();
    if (n == 0) exp_out = in_v;
    else if (hq.size() < n) exp_out = RV;
    else exp_out = hq[n-1];
    exp_pr = (fill_m >= n);
    total++;
    assert (out_v === exp_out) else begin
      bad++;
      $error("FAIL %s out: got %b want %b (N=%0d)", tag, out_v, exp_out, n);
    end
    total++;
    assert (primed === exp_pr) else begin
      bad++;
      $error("FAIL %s primed: got %b want %b (N=%0d fill=%0d)", tag, primed, exp_pr, n, fill_m);
    end
    total++;
    assert (dly_err === err_m) else begin
      bad++;
      $error("FAIL %s dly_err: got %b want %b", tag, dly_err, err_m);
    end
    $display("[%0t] %s in=%b en=%b sel=%0d out=%b primed=%b err=%b", $time, tag, in_v, en, sel,
             out_v, primed, dly_err);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) begin
      hq.push_front(in_v);
      if (hq.size() > MAXD) void'(hq.pop_back());
      if (fill_m < MAXD) fill_m++;
      err_m = en && (int'(sel) > MAXD);
    end
    #1;
    check(tag);
  endtask

  task automatic set_in(input logic [W-1:0] v, input string tag);
    in_v = v;
    #1;
    check(tag);
  endtask

  task automatic assert_reset(input string tag);
    rst_n = 1'b0;
    hq.delete();
    fill_m = 0;
    err_m  = 1'b0;
    #1;
    check(tag);
  endtask

  initial begin
    logic [W-1:0] stream [5];
    stream[0] = 2'b01; stream[1] = 2'b00; stream[2] = 2'b01;
    stream[3] = 2'b01; stream[4] = 2'b00;

    // Reset hold, then default delay of one cycle.
    in_v = 2'b01;
    #3;
    check("rst_hold");
    tick("rst_edge");
    rst_n = 1'b1;
    #1;
    check("rst_release");
    tick("def1_first");

    // Latency with N=3: a single pulse and primed rising after edge 3.
    assert_reset("lat_rst");
    en   = 1'b1;
    sel  = SW'(3);
    in_v = '0;
    #1;
    rst_n = 1'b1;
    #1;
    check("lat_start");
    for (int i = 0; i < 16; i++) begin
      in_v = (i == 9) ? 2'b11 : 2'b00;
      tick("lat");
    end

    // Passthrough: N=0 follows in without a clock edge.
    sel = '0;
    #1;
    check("pass_sel0");
    set_in(2'b10, "pass_a");
    set_in(2'b01, "pass_b");
    set_in(2'b11, "pass_c");
    tick("pass_edge");

    // Live retime from 4 to 2 without touching history.
    sel = SW'(4);
    for (int i = 0; i < 5; i++) begin
      in_v = stream[i];
      tick("retime_stream");
    end
    sel = SW'(2);
    #1;
    check("retime_imm");
    tick("retime_after");
    tick("retime_after");

    // Range error: clamp to MAXD, flag registered on the next edge.
    sel = SW'(MAXD + 1);
    #1;
    check("range_pre");
    tick("range_err");
    in_v = 2'b10;
    tick("range_hold");
    sel = SW'((1 << SW) - 1);
    tick("range_top");
    sel = SW'(5);
    #1;
    check("range_fix_pre");
    tick("range_fix");

    // Asynchronous reset between edges while history holds ones.
    sel  = SW'(3);
    in_v = 2'b11;
    for (int i = 0; i < 4; i++) tick("arst_fill");
    #3;
    assert_reset("arst_mid");
    #3;
    rst_n = 1'b1;
    #1;
    check("arst_release");
    for (int i = 0; i < 4; i++) tick("arst_refill");

    // Random traffic, including mid-cycle delay changes and reset pulses.
    for (int i = 0; i < 400; i++) begin
      in_v = W'($urandom);
      if ($urandom_range(0, 9) == 0) en = ~en;
      if ($urandom_range(0, 3) == 0) sel = SW'($urandom_range(0, MAXD + 3));
      if ($urandom_range(0, 5) == 0) begin
        sel = SW'($urandom_range(0, MAXD + 3));
        #1;
        check("rnd_midsel");
      end
      if ($urandom_range(0, 49) == 0) begin
        assert_reset("rnd_rst");
        rst_n = 1'b1;
        #1;
        check("rnd_rst_rel");
      end
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
